// File: rtl/delay_elastic_pkg.sv
// Shared types for the elastic delay line: the clock/reset control bundle
// and the accessors used to pull the clock and active-low reset out of it.
package delay_elastic_pkg;

  typedef struct packed {
    logic clock;
    logic reset_n;
  } Data_Control_T;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DELAY = 2;

  function automatic logic Data_Control_Clock(input Data_Control_T ctrl);
    return ctrl.clock;
  endfunction

  function automatic logic Data_Control_Reset(input Data_Control_T ctrl);
    return ctrl.reset_n;
  endfunction

endpackage

// File: rtl/delay_elastic_stage.sv
// One register stage of the elastic delay line: a valid bit plus a data word
// that only loads when a real word arrives, so data stays put under bubbles.
module delay_elastic_stage
  import delay_elastic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush wins over advance; data is never touched by flush or by a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/delay_elastic.sv
// Elastic fixed-depth delay line: DELAY stages joined by a combinational
// advance chain, with backpressure, bubble collapse and synchronous flush.
module delay_elastic
  import delay_elastic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DELAY = DEFAULT_DELAY
) (
  input  Data_Control_T                  ctrl,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DELAY+1)-1:0]     count
);

  localparam int CW = $clog2(DELAY+1);

  logic             clk;
  logic             rst_n;
  logic [DELAY-1:0] valid;
  logic [DELAY-1:0] adv;
  logic [DELAY-1:0] up_valid;
  logic [DELAY-1:0] next_valid;
  logic [WIDTH-1:0] data    [DELAY];
  logic [WIDTH-1:0] up_data [DELAY];
  logic             accept;

  assign clk   = Data_Control_Clock(ctrl);
  assign rst_n = Data_Control_Reset(ctrl);

  // A stage moves when it is empty or the stage after it moves; the chain
  // ripples back from the consumer with no registered skid.
  always_comb begin
    adv = '0;
    adv[DELAY-1] = !valid[DELAY-1] || out_ready;
    for (int i = DELAY-2; i >= 0; i--) begin
      adv[i] = !valid[i] || adv[i+1];
    end
  end

  // Gating with rst_n keeps the line closed while reset is held.
  assign in_ready  = adv[0] && !flush && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid[DELAY-1] && !flush;
  assign out       = data[DELAY-1];

  for (genvar i = 0; i < DELAY; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = accept;
      assign up_data[i]  = in;
    end else begin : g_body
      assign up_valid[i] = valid[i-1];
      assign up_data[i]  = data[i-1];
    end

    delay_elastic_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv[i]),
      .flush    (flush),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .valid    (valid[i]),
      .data     (data[i])
    );
  end

  // Occupancy the stages will hold after this edge, so count tracks them exactly.
  always_comb begin
    next_valid = '0;
    if (!flush) begin
      for (int i = 0; i < DELAY; i++) begin
        next_valid[i] = adv[i] ? up_valid[i] : valid[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= CW'($countones(next_valid));
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DELAY));

endmodule

// File: tb/tb_delay_elastic.sv
// Randomized bench for delay_elastic: a DELAY=2 and a DELAY=4 line share one
// stimulus stream and are each compared against a word/position queue model.
module tb_delay_elastic;
  import delay_elastic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  Data_Control_T ctrl;
  assign ctrl = '{clock: clk, reset_n: rst_n};

  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_word = 8'h00;

  logic       in_ready_a, out_valid_a;
  logic [3:0] out_a;
  logic [1:0] count_a;
  logic       in_ready_b, out_valid_b;
  logic [7:0] out_b;
  logic [2:0] count_b;

  delay_elastic #(.WIDTH(4), .DELAY(2)) dut_a (
    .ctrl(ctrl), .flush(flush), .in(in_word[3:0]), .in_valid(in_valid),
    .in_ready(in_ready_a), .out(out_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .count(count_a)
  );

  delay_elastic #(.WIDTH(8), .DELAY(4)) dut_b (
    .ctrl(ctrl), .flush(flush), .in(in_word), .in_valid(in_valid),
    .in_ready(in_ready_b), .out(out_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .count(count_b)
  );

  always #5 clk = ~clk;

  int depth [2] = '{2, 4};
  int wmask [2] = '{32'h0F, 32'hFF};
  int q_n   [2];
  int q_pos [2][8];
  int q_dat [2][8];
  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sampleDut(input int k, output logic [31:0] ir, output logic [31:0] ov,
                           output logic [31:0] o, output logic [31:0] c);
    if (k == 0) begin
      ir = 32'(in_ready_a); ov = 32'(out_valid_a); o = 32'(out_a); c = 32'(count_a);
    end else begin
      ir = 32'(in_ready_b); ov = 32'(out_valid_b); o = 32'(out_b); c = 32'(count_b);
    end
  endtask

  // Words are kept oldest-first with their stage position; each word slides one
  // place toward the output unless blocked by the word in front of it.
  task automatic modelCycle(input int k);
    int d, lim, n;
    int new_pos [8];
    bit removed, exp_ir, exp_ov;
    logic [31:0] ir, ov, o, c;
    d = depth[k];
    removed = 1'b0;
    for (int j = 0; j < q_n[k]; j++) begin
      if (j == 0) begin
        if (q_pos[k][0] == d-1) begin
          new_pos[0] = d-1;
          removed = out_ready;
        end else begin
          new_pos[0] = q_pos[k][0] + 1;
        end
      end else begin
        lim = (j == 1 && removed) ? d : new_pos[j-1];
        new_pos[j] = (q_pos[k][j] + 1 < lim) ? q_pos[k][j] + 1 : lim - 1;
      end
    end
    exp_ov = !flush && q_n[k] > 0 && q_pos[k][0] == d-1;
    exp_ir = !flush && (q_n[k] == 0 || new_pos[q_n[k]-1] > 0);

    sampleDut(k, ir, ov, o, c);
    checkOutput($sformatf("in_ready_d%0d", d), ir, 32'(exp_ir));
    checkOutput($sformatf("out_valid_d%0d", d), ov, 32'(exp_ov));
    checkOutput($sformatf("count_d%0d", d), c, 32'(q_n[k]));
    if (exp_ov) checkOutput($sformatf("out_d%0d", d), o, 32'(q_dat[k][0]));

    if (flush) begin
      q_n[k] = 0;
    end else begin
      n = 0;
      for (int j = (removed ? 1 : 0); j < q_n[k]; j++) begin
        q_pos[k][n] = new_pos[j];
        q_dat[k][n] = q_dat[k][j];
        n++;
      end
      if (exp_ir && in_valid) begin
        q_pos[k][n] = 0;
        q_dat[k][n] = int'(in_word) & wmask[k];
        n++;
      end
      q_n[k] = n;
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit fl, input bit ordy);
    in_valid  = v;
    in_word   = d;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    modelCycle(0);
    modelCycle(1);
    @(posedge clk);
    #1;
  endtask

  // Reset is dropped between edges and must clear everything without a clock.
  task automatic applyReset();
    logic [31:0] ir, ov, o, c;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      sampleDut(k, ir, ov, o, c);
      checkOutput($sformatf("rst_out_valid_d%0d", depth[k]), ov, 32'd0);
      checkOutput($sformatf("rst_count_d%0d", depth[k]), c, 32'd0);
      checkOutput($sformatf("rst_in_ready_d%0d", depth[k]), ir, 32'd0);
      checkOutput($sformatf("rst_out_d%0d", depth[k]), o, 32'd0);
      q_n[k] = 0;
    end
    in_valid = 1'b1;
    flush = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_held_in_ready_d2", 32'(in_ready_a), 32'd0);
    checkOutput("rst_held_in_ready_d4", 32'(in_ready_b), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    q_n = '{0, 0};
    #2;
    applyReset();

    $display("[TB] latency stream");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h09, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 8'($urandom),
                    $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
